// File: rtl/axiburst_user_arbiter.sv
// axiburst_user_arbiter
//   Shares the single user command port of the AXI burst master between
//   NUM_REQ requesters. One command is in flight at a time: the winner is
//   accepted (req_ready pulse), its command is latched and launched with a
//   one-cycle m_start, and the write-stall / read-strobe lines are steered to
//   the granted requester until the master returns to idle, at which point
//   req_done pulses for that requester.
//
//   Optional feature macro: AXIBURST_ARB_PRIORITY_EN
//     defined   : requester 0 has strict priority, 1..NUM_REQ-1 round-robin
//     undefined : plain round-robin over all requesters
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   req_*               per-requester packed buses, requester i at slice i
//   req_rdata           read data broadcast to all requesters
//   req_status          master status captured on completion
//   m_*                 burst master user command / data port
module axiburst_user_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int STRB_W  = DATA_W / 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_w_r,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]        req_len,
  input  logic [NUM_REQ*STRB_W-1:0]   req_strb,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_wstall,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [NUM_REQ-1:0]          req_rdata_en,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [1:0]                  req_status,
  output logic                        m_start,
  output logic                        m_w_r,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [7:0]                  m_burst_len,
  output logic [DATA_W-1:0]           m_data_in,
  output logic [STRB_W-1:0]           m_data_strb,
  input  logic                        m_free,
  input  logic                        m_stall_w_data,
  input  logic                        m_stall_r_data,
  input  logic [DATA_W-1:0]           m_data_out,
  input  logic                        m_data_out_en,
  input  logic [1:0]                  m_status
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_FREE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                w_r_q, w_r_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [1:0]          status_q, status_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic                accept;

  // Read stall is handled inside the master; clients see only rdata_en.
  logic unused_rstall;
  assign unused_rstall = m_stall_r_data;

  // Arbitration: scan from the pointer, first valid requester wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
`ifdef AXIBURST_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
    // Requester 0 is skipped in the scan; a pointer of 0 thus starts at 1.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && idx != 0 && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
`endif
  end

  assign accept = (state_q == S_IDLE) && m_free && win_found;

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      w_r_q    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      strb_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      w_r_q    <= w_r_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      strb_q   <= strb_d;
      status_q <= status_d;
    end
  end

  // Next-state and command latch
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    w_r_d    = w_r_q;
    addr_d   = addr_q;
    len_d    = len_q;
    strb_d   = strb_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_START;
        grant_d = win_idx;
        ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        w_r_d   = req_w_r[win_idx];
        addr_d  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        len_d   = req_len[int'(win_idx)*8 +: 8];
        strb_d  = req_strb[int'(win_idx)*STRB_W +: STRB_W];
      end
      S_START:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!m_free) state_d = S_WAIT_FREE;
      S_WAIT_FREE: if (m_free) state_d = S_DONE;
      S_DONE: begin
        state_d  = S_IDLE;
        status_d = m_status;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs and data steering
  always_comb begin
    req_ready    = '0;
    req_done     = '0;
    req_wstall   = '1;
    req_rdata_en = '0;
    m_data_in    = '0;
    m_start      = (state_q == S_START);
    if (accept) req_ready[win_idx] = 1'b1;
    if (state_q == S_DONE) req_done[grant_q] = 1'b1;
    if (state_q != S_IDLE) begin
      m_data_in             = req_wdata[int'(grant_q)*DATA_W +: DATA_W];
      req_wstall[grant_q]   = m_stall_w_data;
      req_rdata_en[grant_q] = m_data_out_en;
    end
  end

  assign req_rdata   = m_data_out;
  assign req_status  = status_q;
  assign m_w_r       = w_r_q;
  assign m_addr      = addr_q;
  assign m_burst_len = len_q;
  assign m_data_strb = strb_q;

endmodule

// File: tb/tb_axiburst_user_arbiter.sv
// Directed bench for axiburst_user_arbiter (NUM_REQ=2). The bench plays the
// burst master cycle by cycle; inputs change 1ns after the rising edge and
// outputs are checked 1ns later or counted on the falling edge.
module tb_axiburst_user_arbiter;
  localparam int NR = 2, AW = 32, DW = 64, SW = 8;

  logic            aclk = 0, areset = 1;
  logic [NR-1:0]   req_valid = '0, req_ready, req_w_r = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*8-1:0] req_len = '0;
  logic [NR*SW-1:0] req_strb = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]   req_wstall, req_rdata_en, req_done;
  logic [DW-1:0]   req_rdata;
  logic [1:0]      req_status;
  logic            m_start, m_w_r;
  logic [AW-1:0]   m_addr;
  logic [7:0]      m_burst_len;
  logic [DW-1:0]   m_data_in;
  logic [SW-1:0]   m_data_strb;
  logic            m_free = 1, m_stall_w_data = 1, m_stall_r_data = 1;
  logic [DW-1:0]   m_data_out = '0;
  logic            m_data_out_en = 0;
  logic [1:0]      m_status = '0;

  axiburst_user_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_w_r(req_w_r),
    .req_addr(req_addr), .req_len(req_len), .req_strb(req_strb),
    .req_wdata(req_wdata), .req_wstall(req_wstall), .req_rdata(req_rdata),
    .req_rdata_en(req_rdata_en), .req_done(req_done), .req_status(req_status),
    .m_start(m_start), .m_w_r(m_w_r), .m_addr(m_addr), .m_burst_len(m_burst_len),
    .m_data_in(m_data_in), .m_data_strb(m_data_strb), .m_free(m_free),
    .m_stall_w_data(m_stall_w_data), .m_stall_r_data(m_stall_r_data),
    .m_data_out(m_data_out), .m_data_out_en(m_data_out_en), .m_status(m_status)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_pass = 0;
  int fall0 = 0, done0 = 0, done1 = 0, ren0 = 0, ren1 = 0, ws1_low = 0;
  logic prev_ws0 = 1'b1;

  always @(negedge aclk) begin
    if (prev_ws0 && !req_wstall[0]) fall0 <= fall0 + 1;
    prev_ws0 <= req_wstall[0];
    if (req_done[0])     done0 <= done0 + 1;
    if (req_done[1])     done1 <= done1 + 1;
    if (req_rdata_en[0]) ren0  <= ren0 + 1;
    if (req_rdata_en[1]) ren1  <= ren1 + 1;
    if (!req_wstall[1])  ws1_low <= ws1_low + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    areset = 1; m_free = 1; req_valid = '0;
    step(); step();
    areset = 0;
  endtask

  // Called just after the accept edge (DUT in START). Plays the master for
  // a burst of 'beats' beats and checks the done/status handshake.
  task automatic run_burst(input int g, input bit rd, input int beats, input logic [1:0] st);
    int d0, d1;
    d0 = done0; d1 = done1;
    #1 chk("m_start_pulse", m_start, 1);
    step(); m_free = 0;
    #1 chk("m_start_low", m_start, 0);
    step();
    for (int i = 0; i < beats; i++) begin
      if (rd) begin
        m_data_out = 64'hA5A5_0000_0000_0000 + 64'(i);
        m_data_out_en = 1;
        #1;
        if (i == 0) chk("rdata_en_route", req_rdata_en, (g == 1) ? 2'b10 : 2'b01);
        if (req_rdata !== 64'hA5A5_0000_0000_0000 + 64'(i)) chk("rdata_beat", req_rdata, 64'hA5A5_0000_0000_0000 + 64'(i));
        step(); m_data_out_en = 0;
      end else begin
        req_wdata[g*DW +: DW] = 64'hC0DE_0000_0000_0000 + 64'(i);
        m_stall_w_data = 0;
        #1;
        if (m_data_in !== 64'hC0DE_0000_0000_0000 + 64'(i)) chk("wdata_beat", m_data_in, 64'hC0DE_0000_0000_0000 + 64'(i));
        step(); m_stall_w_data = 1;
      end
      step();
    end
    m_free = 1; m_status = st;
    step();
    chk("done_pulse", req_done, (g == 1) ? 2'b10 : 2'b01);
    step();
    chk("done_low", req_done, 0);
    chk("status", req_status, st);
    #1 chk("done_once", (done0 - d0) + (done1 - d1), 1);
  endtask

  initial begin
    int f0, r0, r1, w1, d0;
    logic [1:0] exp_g;
    do_reset();
    // reset state
    chk("rst_ready", req_ready, 0);
    chk("rst_done", req_done, 0);
    chk("rst_status", req_status, 0);
    chk("rst_start", m_start, 0);
    chk("rst_cmd", {m_w_r, m_addr, m_burst_len, m_data_strb}, 0);
    chk("rst_wstall", req_wstall, 2'b11);
    chk("rst_rden", req_rdata_en, 0);

    // single write from r0
    req_w_r[0] = 0; req_addr[AW-1:0] = 32'h1000_0040; req_len[7:0] = 8'd15; req_strb[SW-1:0] = 8'hFF;
    req_valid[0] = 1;
    #1 chk("wr_ready", req_ready, 2'b01);
    f0 = fall0; w1 = ws1_low;
    step(); req_valid[0] = 0;
    chk("wr_cmd", {m_w_r, m_addr, m_burst_len, m_data_strb}, {1'b0, 32'h1000_0040, 8'd15, 8'hFF});
    run_burst(0, 0, 16, 2'b00);
    chk("wr_falls", fall0 - f0, 16);
    chk("wr_ws1_high", ws1_low - w1, 0);
    chk("wr_cmd_hold", m_addr, 32'h1000_0040);

    // simultaneous requests after reset
    do_reset();
    req_len = '0; req_valid = 2'b11;
    #1 chk("sim_first", req_ready, 2'b01);
    step(); req_valid[0] = 0;
    run_burst(0, 0, 1, 2'b10);
    #1 chk("sim_second", req_ready, 2'b10);
    step(); req_valid[1] = 0;
    run_burst(1, 0, 1, 2'b01);
    req_valid = 2'b11;
    #1 chk("sim_third", req_ready, 2'b01);
    step(); req_valid[0] = 0;
    run_burst(0, 0, 1, 2'b00);
    req_valid = '0;

    // read burst by r1
    req_w_r[1] = 1; req_addr[2*AW-1:AW] = 32'h2000_0CC0; req_len[15:8] = 8'd3;
    req_valid[1] = 1;
    #1 chk("rd_ready", req_ready, 2'b10);
    r0 = ren0; r1 = ren1;
    step(); req_valid[1] = 0;
    chk("rd_cmd", {m_w_r, m_addr, m_burst_len}, {1'b1, 32'h2000_0CC0, 8'd3});
    run_burst(1, 1, 4, 2'b11);
    chk("rd_en1_count", ren1 - r1, 4);
    chk("rd_en0_count", ren0 - r0, 0);

    // m_free low blocks acceptance
    m_free = 0; req_valid[0] = 1;
    for (int i = 0; i < 3; i++) begin
      #1 if (req_ready !== 2'b00) chk("busy_no_ready", req_ready, 0);
      step();
    end
    chk("busy_no_start", m_start, 0);
    m_free = 1;
    #1 chk("free_ready", req_ready, 2'b01);
    step(); req_valid[0] = 0;
    run_burst(0, 0, 2, 2'b00);

    // reset in WAIT_FREE
    req_valid[0] = 1;
    step(); req_valid[0] = 0;
    step(); m_free = 0;
    step(); // now waiting for the master to go free
    d0 = done0;
    areset = 1;
    step(); areset = 0; m_free = 1;
    #1 chk("mr_start", m_start, 0);
    chk("mr_wstall", req_wstall, 2'b11);
    chk("mr_cmd", {m_w_r, m_addr, m_burst_len, m_data_strb}, 0);
    chk("mr_done", req_done, 0);
    step();
    chk("mr_no_done", done0 - d0, 0);
    req_valid[1] = 1;
    #1 chk("mr_idle", req_ready, 2'b10);
    req_valid = '0;

    // both held valid: grant sequence
    do_reset();
    req_valid = 2'b11;
    for (int n = 0; n < 3; n++) begin
`ifdef AXIBURST_ARB_PRIORITY_EN
      exp_g = 2'b01;
`else
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
      #1 chk("alt_grant", req_ready, exp_g);
      step();
      run_burst(exp_g[1] ? 1 : 0, 0, 1, 2'b00);
    end
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
